// File: rtl/pipe_skid_buf.sv
// Elastic pipeline stage: registered in_ready, one main entry plus one skid entry.
// Optional backpressure cycle counter enabled by PIPE_SKID_STALL_CNT_EN.
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | no payload held, out_valid low
// ST_BUSY  | main entry valid, skid entry free
// ST_FULL  | main and skid entries valid, in_ready low
module pipe_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic [DATA_WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  in_fire;
    logic                  out_fire;
    logic                  load_main;
    logic                  main_from_skid;
    logic                  load_skid;

    // in_ready is a flop fed from the next state, so it never depends
    // combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt != ST_FULL);
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) state_nxt = ST_BUSY;
                ST_BUSY: begin
                    if (in_fire && !out_fire)      state_nxt = ST_FULL;
                    else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (out_fire) state_nxt = ST_BUSY;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid      = (state_q != ST_EMPTY);
        in_ready       = in_ready_q;
        in_fire        = in_valid && in_ready_q;
        out_fire       = out_valid && out_ready;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: load_main = in_fire;
                ST_BUSY: begin
                    load_main = in_fire && out_fire;
                    load_skid = in_fire && !out_fire;
                end
                ST_FULL: begin
                    load_main      = out_fire;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Flush leaves the data registers untouched; only the state is emptied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_skid) skid_q <= in_data;
            if (load_main) main_q <= main_from_skid ? skid_q : in_data;
        end
    end

    assign out_data = main_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Scoreboard bench for pipe_skid_buf: driver pushes accepted beats, monitor pops on out_fire.
// Counter checks are active when PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [31:0] stall_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] q[$];
    int          occ_now = 0;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0] exp_stall = '0;
`endif

    pipe_skid_buf #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_SKID_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_data  (out_data)
    );

`ifndef PIPE_SKID_STALL_CNT_EN
    assign stall_cnt = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: occupancy snapshot, scoreboard pop, flush/reset discard.
    always @(negedge clk or posedge rst) begin
        occ_now = q.size();
        if (rst) begin
            q.delete();
`ifdef PIPE_SKID_STALL_CNT_EN
            exp_stall = '0;
`endif
        end else begin
`ifdef PIPE_SKID_STALL_CNT_EN
            check("stall_cnt_model", stall_cnt, exp_stall);
            if (out_valid && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
            if (flush) begin
                q.delete();
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", out_data, $time);
                end else begin
                    check("out_data_order", out_data, q.pop_front());
                end
            end
        end
    end

    // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, output logic fired);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        fired     = 1'b0;
        @(negedge clk);
        #1;
        if (!rst) begin
            check("out_valid_model", out_valid, occ_now > 0);
            check("in_ready_model", in_ready, occ_now < 2);
            if (iv && in_ready) begin
                fired = 1'b1;
                if (!fl) q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic f;
        int   sent;
        int   cycles;

        #1;
        check("reset_out_valid_async", out_valid, 1'b0);
        check("reset_out_data_async", out_data, 32'h0);
        do_reset();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_data", out_data, 32'h0);

        // Streaming
        cyc(1'b1, 32'h1, 1'b1, 1'b0, f);
        check("stream_d1", out_data, 32'h1);
        cyc(1'b1, 32'h2, 1'b1, 1'b0, f);
        check("stream_d2", out_data, 32'h2);
        check("stream_in_ready", in_ready, 1'b1);
        cyc(1'b1, 32'h3, 1'b1, 1'b0, f);
        check("stream_d3", out_data, 32'h3);
        check("stream_valid", out_valid, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, f);
        check("stream_drained", out_valid, 1'b0);

        // Skid fill and release
        cyc(1'b1, 32'hA, 1'b0, 1'b0, f);
        check("skid_busy_in_ready", in_ready, 1'b1);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, f);
        check("skid_full_in_ready", in_ready, 1'b0);
        check("skid_full_out_data", out_data, 32'hA);
        cyc(1'b1, 32'hEE, 1'b0, 1'b0, f);
        check("skid_hold_out_data", out_data, 32'hA);
        check("skid_hold_no_accept", f, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, f);
        check("skid_release_in_ready", in_ready, 1'b1);
        check("skid_release_out_data", out_data, 32'hB);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, f);
        check("skid_empty", out_valid, 1'b0);

        // Flush from FULL with a concurrent in_valid
        cyc(1'b1, 32'hA, 1'b0, 1'b0, f);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, f);
        check("flush_pre_full", in_ready, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b1, f);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, f);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, f);
        check("flush_no_c", out_valid, 1'b0);

        // Async reset mid-cycle
        cyc(1'b1, 32'h55, 1'b0, 1'b0, f);
        check("areset_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("areset_out_valid", out_valid, 1'b0);
        check("areset_in_ready", in_ready, 1'b1);
        check("areset_out_data", out_data, 32'h0);
        do_reset();

`ifdef PIPE_SKID_STALL_CNT_EN
        cyc(1'b1, 32'h7, 1'b0, 1'b0, f);
        repeat (5) cyc(1'b0, 32'h0, 1'b0, 1'b0, f);
        check("stall_cnt_5", stall_cnt, 32'd5);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, f);
        check("stall_cnt_after_flush", stall_cnt, 32'd5);
        do_reset();
        check("stall_cnt_reset", stall_cnt, 32'd0);
`endif

        // Random valid/ready, incrementing data 0..9999
        sent = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 60000) begin
            cyc(1'($urandom_range(0, 1)), sent, 1'($urandom_range(0, 1)), 1'b0, f);
            if (f) sent++;
            cycles++;
        end
        if (sent < 10000) begin
            n_checks++;
            n_fail++;
            $display("FAIL random_timeout: got %0d beats expected 10000", sent);
        end
        repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0, f);
        check("random_drained_queue", q.size(), 32'd0);
        check("random_drained_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
